// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
//   ROB_WIDTH   : width of reorder-buffer tags
//   OPC_*       : RV32I opcodes of the instruction classes routed to this RS
//   rob_tag_t   : ROB tag type
//   cdb_t       : one result broadcast (valid, tag, value)
//   rs_entry_t  : one reservation-station slot
//   operand_t   : operand value plus its ready flag
//   snoop()     : resolves a not-yet-ready operand against both broadcasts
package alu_rs_pkg;

    localparam int ROB_WIDTH = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef logic [ROB_WIDTH-1:0] rob_tag_t;

    typedef struct packed {
        logic        valid;
        rob_tag_t    tag;
        logic [31:0] val;
    } cdb_t;

    typedef struct packed {
        logic        busy;
        logic [6:0]  opcode;
        logic [2:0]  precise;
        logic        more_precise;
        logic [31:0] imm;
        logic [31:0] pc;
        rob_tag_t    rob_entry;
        logic [31:0] vj;
        logic [31:0] vk;
        logic        j_ready;
        logic        k_ready;
        rob_tag_t    qj;
        rob_tag_t    qk;
    } rs_entry_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] val;
    } operand_t;

    // An already-ready operand passes through untouched. Otherwise the ALU
    // broadcast is checked first; the two units never complete the same tag
    // in one cycle, so the order only matters for malformed traffic.
    function automatic operand_t snoop(input logic        ready,
                                       input logic [31:0] val,
                                       input rob_tag_t    q,
                                       input cdb_t        alu,
                                       input cdb_t        lsb);
        operand_t r;
        r.ready = ready;
        r.val   = val;
        if (!ready) begin
            if (alu.valid && alu.tag == q) begin
                r.ready = 1'b1;
                r.val   = alu.val;
            end else if (lsb.valid && lsb.tag == q) begin
                r.ready = 1'b1;
                r.val   = lsb.val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Bus bundle between dispatcher / CDB / ALU and the reservation station.
//   in_*        : dispatched instruction (in_config = insert strobe)
//   alu_*, lsb_*: result broadcasts snooped for operand wakeup
//   out_full    : no free slot this cycle
//   out_*       : registered issue bus to the ALU (out_config = issue strobe)
// modport master: dispatcher/CDB/ALU side; modport slave: reservation station.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic        in_config;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [31:0] in_imm;
    logic [31:0] in_PC;
    rob_tag_t    in_rob_entry;
    logic [31:0] in_Vj;
    logic [31:0] in_Vk;
    logic        in_j_ready;
    logic        in_k_ready;
    rob_tag_t    in_Qj;
    rob_tag_t    in_Qk;

    logic        alu_config;
    logic [31:0] alu_val;
    rob_tag_t    alu_rob_entry;
    logic        lsb_config;
    logic [31:0] lsb_val;
    rob_tag_t    lsb_rob_entry;

    logic        out_full;
    logic        out_config;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_PC;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_precise;
    logic        out_more_precise;
    rob_tag_t    out_rob_entry;

    modport master (
        output in_config, in_opcode, in_precise, in_more_precise, in_imm, in_PC,
               in_rob_entry, in_Vj, in_Vk, in_j_ready, in_k_ready, in_Qj, in_Qk,
               alu_config, alu_val, alu_rob_entry,
               lsb_config, lsb_val, lsb_rob_entry,
        input  out_full, out_config, out_a, out_b, out_PC, out_imm,
               out_opcode, out_precise, out_more_precise, out_rob_entry
    );

    modport slave (
        input  in_config, in_opcode, in_precise, in_more_precise, in_imm, in_PC,
               in_rob_entry, in_Vj, in_Vk, in_j_ready, in_k_ready, in_Qj, in_Qk,
               alu_config, alu_val, alu_rob_entry,
               lsb_config, lsb_val, lsb_rob_entry,
        output out_full, out_config, out_a, out_b, out_PC, out_imm,
               out_opcode, out_precise, out_more_precise, out_rob_entry
    );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one bit set
module rs_prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan downwards so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station. Holds dispatched integer/branch/JAL/AUIPC
// instructions until both operands are known, snooping the ALU and LSB
// broadcasts, and issues at most one ready entry per cycle onto a registered
// ALU input bus.
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global enable; everything holds while low
//   rollback_config : flush all entries (mispredict)
//   bus             : alu_rs_if.slave (dispatch, broadcasts, issue, out_full)
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     rollback_config,
    alu_rs_if.slave  bus
);

    localparam int IDXW = $clog2(RS_SIZE);

    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDXW-1:0]    free_idx;
    logic [IDXW-1:0]    issue_idx;
    logic               free_found;
    logic               issue_found;
    logic               ins_en;

    cdb_t      alu_cdb;
    cdb_t      lsb_cdb;
    operand_t  in_j;
    operand_t  in_k;
    rs_entry_t in_ent;

    logic        out_config_q;
    logic [31:0] out_a_q;
    logic [31:0] out_b_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_imm_q;
    logic [6:0]  out_opcode_q;
    logic [2:0]  out_precise_q;
    logic        out_more_precise_q;
    rob_tag_t    out_rob_entry_q;

    assign alu_cdb = {bus.alu_config, bus.alu_rob_entry, bus.alu_val};
    assign lsb_cdb = {bus.lsb_config, bus.lsb_rob_entry, bus.lsb_val};

    // Both selections look only at registered state, so an entry woken or
    // inserted this cycle cannot issue until next cycle, and a slot emptied
    // by this cycle's issue is not visible as free until next cycle.
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_vec
        assign free_vec[gi]  = ~ent_q[gi].busy;
        assign ready_vec[gi] = ent_q[gi].busy & ent_q[gi].j_ready & ent_q[gi].k_ready;
    end

    rs_prio_enc #(.N(RS_SIZE)) u_free_sel (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE)) u_issue_sel (
        .req_i   (ready_vec),
        .idx_o   (issue_idx),
        .found_o (issue_found)
    );

    assign bus.out_full = ~free_found;
    // An insert while full has nowhere to go and is silently dropped.
    assign ins_en       = bus.in_config & free_found;

    // Incoming instruction, with same-cycle broadcast bypass on its operands.
    always_comb begin
        in_j = snoop(bus.in_j_ready, bus.in_Vj, bus.in_Qj, alu_cdb, lsb_cdb);
        in_k = snoop(bus.in_k_ready, bus.in_Vk, bus.in_Qk, alu_cdb, lsb_cdb);
        in_ent              = '0;
        in_ent.busy         = 1'b1;
        in_ent.opcode       = bus.in_opcode;
        in_ent.precise      = bus.in_precise;
        in_ent.more_precise = bus.in_more_precise;
        in_ent.imm          = bus.in_imm;
        in_ent.pc           = bus.in_PC;
        in_ent.rob_entry    = bus.in_rob_entry;
        in_ent.vj           = in_j.val;
        in_ent.j_ready      = in_j.ready;
        in_ent.vk           = in_k.val;
        in_ent.k_ready      = in_k.ready;
        in_ent.qj           = bus.in_Qj;
        in_ent.qk           = bus.in_Qk;
    end

    // Per-slot next state: wakeup, issue release, insert. Insert only targets
    // a free slot and issue only a busy one, so the two never collide.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                {ent_d[i].j_ready, ent_d[i].vj} =
                    snoop(ent_q[i].j_ready, ent_q[i].vj, ent_q[i].qj, alu_cdb, lsb_cdb);
                {ent_d[i].k_ready, ent_d[i].vk} =
                    snoop(ent_q[i].k_ready, ent_q[i].vk, ent_q[i].qk, alu_cdb, lsb_cdb);
            end
            if (issue_found && issue_idx == IDXW'(i)) begin
                ent_d[i].busy = 1'b0;
            end
            if (ins_en && free_idx == IDXW'(i)) begin
                ent_d[i] = in_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback_config) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i].busy <= 1'b0;
            end
            out_config_q       <= 1'b0;
            out_a_q            <= '0;
            out_b_q            <= '0;
            out_pc_q           <= '0;
            out_imm_q          <= '0;
            out_opcode_q       <= '0;
            out_precise_q      <= '0;
            out_more_precise_q <= 1'b0;
            out_rob_entry_q    <= '0;
        end else if (rdy) begin
            ent_q <= ent_d;
            if (issue_found) begin
                out_config_q       <= 1'b1;
                out_a_q            <= ent_q[issue_idx].vj;
                out_b_q            <= ent_q[issue_idx].vk;
                out_pc_q           <= ent_q[issue_idx].pc;
                out_imm_q          <= ent_q[issue_idx].imm;
                out_opcode_q       <= ent_q[issue_idx].opcode;
                out_precise_q      <= ent_q[issue_idx].precise;
                out_more_precise_q <= ent_q[issue_idx].more_precise;
                out_rob_entry_q    <= ent_q[issue_idx].rob_entry;
            end else begin
                // Data outputs keep their last value; only the strobe drops.
                out_config_q <= 1'b0;
            end
        end
    end

    assign bus.out_config       = out_config_q;
    assign bus.out_a            = out_a_q;
    assign bus.out_b            = out_b_q;
    assign bus.out_PC           = out_pc_q;
    assign bus.out_imm          = out_imm_q;
    assign bus.out_opcode       = out_opcode_q;
    assign bus.out_precise      = out_precise_q;
    assign bus.out_more_precise = out_more_precise_q;
    assign bus.out_rob_entry    = out_rob_entry_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback_config;

    int vectors     = 0;
    int miscompares = 0;

    alu_rs_if bus ();

    alu_rs #(.RS_SIZE(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback_config (rollback_config),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_config       = 1'b0;
        bus.in_opcode       = '0;
        bus.in_precise      = '0;
        bus.in_more_precise = 1'b0;
        bus.in_imm          = '0;
        bus.in_PC           = '0;
        bus.in_rob_entry    = '0;
        bus.in_Vj           = '0;
        bus.in_Vk           = '0;
        bus.in_j_ready      = 1'b0;
        bus.in_k_ready      = 1'b0;
        bus.in_Qj           = '0;
        bus.in_Qk           = '0;
        bus.alu_config      = 1'b0;
        bus.alu_val         = '0;
        bus.alu_rob_entry   = '0;
        bus.lsb_config      = 1'b0;
        bus.lsb_val         = '0;
        bus.lsb_rob_entry   = '0;
    endtask

    task automatic set_insert(input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                              input logic jr, input logic kr, input logic [3:0] qj, input logic [3:0] qk);
        bus.in_config    = 1'b1;
        bus.in_opcode    = OPC_OP;
        bus.in_precise   = 3'b000;
        bus.in_imm       = 32'h0;
        bus.in_PC        = 32'h1000 + {28'h0, rob};
        bus.in_rob_entry = rob;
        bus.in_Vj        = vj;
        bus.in_Vk        = vk;
        bus.in_j_ready   = jr;
        bus.in_k_ready   = kr;
        bus.in_Qj        = qj;
        bus.in_Qk        = qk;
        $display("insert rob=%0d vj=%h vk=%h jr=%0b kr=%0b qj=%0d qk=%0d", rob, vj, vk, jr, kr, qj, qk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback_config = 1'b0;
        clear_in();
        step();
        step();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL reset_cfg: got %0b want 0", bus.out_config); end
        vectors++; if (bus.out_a !== 32'h0) begin miscompares++; $display("FAIL reset_a: got %h want 0", bus.out_a); end
        vectors++; if (bus.out_PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", bus.out_PC); end
        vectors++; if (bus.out_rob_entry !== 4'h0) begin miscompares++; $display("FAIL reset_rob: got %0d want 0", bus.out_rob_entry); end
        vectors++; if (bus.out_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b want 0", bus.out_full); end
        rst = 1'b0;
        step();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL reset_idle_cfg: got %0b want 0", bus.out_config); end
    endtask

    task automatic test_basic_issue();
        set_insert(4'd3, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0);
        step();
        clear_in();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL basic_no_same_cycle: got %0b want 0", bus.out_config); end
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL basic_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_a !== 32'd5) begin miscompares++; $display("FAIL basic_a: got %h want 5", bus.out_a); end
        vectors++; if (bus.out_b !== 32'd7) begin miscompares++; $display("FAIL basic_b: got %h want 7", bus.out_b); end
        vectors++; if (bus.out_rob_entry !== 4'd3) begin miscompares++; $display("FAIL basic_rob: got %0d want 3", bus.out_rob_entry); end
        vectors++; if (bus.out_PC !== 32'h1003) begin miscompares++; $display("FAIL basic_pc: got %h want 1003", bus.out_PC); end
        vectors++; if (bus.out_opcode !== OPC_OP) begin miscompares++; $display("FAIL basic_opcode: got %b want %b", bus.out_opcode, OPC_OP); end
        step();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL basic_cfg_drop: got %0b want 0", bus.out_config); end
        vectors++; if (bus.out_a !== 32'd5) begin miscompares++; $display("FAIL basic_a_hold: got %h want 5", bus.out_a); end
    endtask

    task automatic test_wakeup();
        set_insert(4'd4, 32'h0, 32'h1, 1'b0, 1'b1, 4'd2, 4'd0);
        step();
        clear_in();
        step();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL wake_wait: got %0b want 0", bus.out_config); end
        bus.alu_config = 1'b1; bus.alu_rob_entry = 4'd2; bus.alu_val = 32'h10;
        step();
        clear_in();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL wake_no_same_cycle: got %0b want 0", bus.out_config); end
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL wake_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_a !== 32'h10) begin miscompares++; $display("FAIL wake_a: got %h want 10", bus.out_a); end
        vectors++; if (bus.out_b !== 32'h1) begin miscompares++; $display("FAIL wake_b: got %h want 1", bus.out_b); end
        vectors++; if (bus.out_rob_entry !== 4'd4) begin miscompares++; $display("FAIL wake_rob: got %0d want 4", bus.out_rob_entry); end
        step();
    endtask

    task automatic test_bypass();
        set_insert(4'd5, 32'h3, 32'h0, 1'b1, 1'b0, 4'd0, 4'd9);
        bus.lsb_config = 1'b1; bus.lsb_rob_entry = 4'd9; bus.lsb_val = 32'hABCD;
        step();
        clear_in();
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL bypass_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_b !== 32'hABCD) begin miscompares++; $display("FAIL bypass_b: got %h want abcd", bus.out_b); end
        vectors++; if (bus.out_a !== 32'h3) begin miscompares++; $display("FAIL bypass_a: got %h want 3", bus.out_a); end
        vectors++; if (bus.out_rob_entry !== 4'd5) begin miscompares++; $display("FAIL bypass_rob: got %0d want 5", bus.out_rob_entry); end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            set_insert(4'(i), 32'h0, 32'h0, 1'b0, 1'b1, 4'(i + 8), 4'd0);
            step();
            if (i == 6) begin
                vectors++; if (bus.out_full !== 1'b0) begin miscompares++; $display("FAIL full_seven: got %0b want 0", bus.out_full); end
            end
        end
        clear_in();
        vectors++; if (bus.out_full !== 1'b1) begin miscompares++; $display("FAIL full_eight: got %0b want 1", bus.out_full); end
        // Insert while full must be dropped.
        set_insert(4'd9, 32'hEE, 32'hEE, 1'b1, 1'b1, 4'd0, 4'd0);
        step();
        clear_in();
        bus.alu_config = 1'b1; bus.alu_rob_entry = 4'd13; bus.alu_val = 32'h55;
        step();
        clear_in();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL full_drop: got %0b want 0", bus.out_config); end
        vectors++; if (bus.out_full !== 1'b1) begin miscompares++; $display("FAIL full_woken: got %0b want 1", bus.out_full); end
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL full_issue_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_rob_entry !== 4'd5) begin miscompares++; $display("FAIL full_issue_rob: got %0d want 5", bus.out_rob_entry); end
        vectors++; if (bus.out_a !== 32'h55) begin miscompares++; $display("FAIL full_issue_a: got %h want 55", bus.out_a); end
        vectors++; if (bus.out_full !== 1'b0) begin miscompares++; $display("FAIL full_release: got %0b want 0", bus.out_full); end
        set_insert(4'd5, 32'h77, 32'h1, 1'b1, 1'b1, 4'd0, 4'd0);
        step();
        clear_in();
        vectors++; if (bus.out_full !== 1'b1) begin miscompares++; $display("FAIL full_refill: got %0b want 1", bus.out_full); end
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL full_slot5_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_a !== 32'h77) begin miscompares++; $display("FAIL full_slot5_a: got %h want 77", bus.out_a); end
        step();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL full_tail: got %0b want 0", bus.out_config); end
    endtask

    task automatic test_rollback();
        rollback_config = 1'b1;
        step();
        rollback_config = 1'b0;
        vectors++; if (bus.out_full !== 1'b0) begin miscompares++; $display("FAIL rb_clear_full: got %0b want 0", bus.out_full); end
        vectors++; if (bus.out_a !== 32'h0) begin miscompares++; $display("FAIL rb_clear_a: got %h want 0", bus.out_a); end
        vectors++; if (bus.out_rob_entry !== 4'h0) begin miscompares++; $display("FAIL rb_clear_rob: got %0d want 0", bus.out_rob_entry); end
        for (int i = 0; i < 4; i++) begin
            set_insert(4'(i + 10), 32'h0, 32'h0, 1'b0, 1'b1, 4'(i + 1), 4'd0);
            step();
        end
        clear_in();
        rollback_config = 1'b1;
        bus.alu_config = 1'b1; bus.alu_rob_entry = 4'd1; bus.alu_val = 32'h99;
        bus.lsb_config = 1'b1; bus.lsb_rob_entry = 4'd2; bus.lsb_val = 32'h98;
        set_insert(4'd14, 32'h1, 32'h1, 1'b1, 1'b1, 4'd0, 4'd0);
        step();
        rollback_config = 1'b0;
        clear_in();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL rb_cfg: got %0b want 0", bus.out_config); end
        vectors++; if (bus.out_full !== 1'b0) begin miscompares++; $display("FAIL rb_full: got %0b want 0", bus.out_full); end
        for (int t = 1; t <= 4; t++) begin
            bus.alu_config = 1'b1; bus.alu_rob_entry = 4'(t); bus.alu_val = 32'h40 + 32'(t);
            step();
        end
        clear_in();
        for (int t = 0; t < 3; t++) begin
            step();
            vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL rb_no_issue: got %0b rob %0d want 0", bus.out_config, bus.out_rob_entry); end
        end
    endtask

    task automatic test_rdy_stall();
        set_insert(4'd7, 32'h0, 32'h2, 1'b0, 1'b1, 4'd3, 4'd0);
        step();
        clear_in();
        bus.alu_config = 1'b1; bus.alu_rob_entry = 4'd3; bus.alu_val = 32'h30;
        set_insert(4'd8, 32'h1, 32'h1, 1'b1, 1'b1, 4'd0, 4'd0);
        rdy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL stall_cfg: got %0b want 0", bus.out_config); end
        end
        rdy = 1'b1;
        step();
        clear_in();
        vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL stall_resume_wait: got %0b want 0", bus.out_config); end
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL stall_first_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_rob_entry !== 4'd7) begin miscompares++; $display("FAIL stall_first_rob: got %0d want 7", bus.out_rob_entry); end
        vectors++; if (bus.out_a !== 32'h30) begin miscompares++; $display("FAIL stall_first_a: got %h want 30", bus.out_a); end
        rdy = 1'b0;
        step();
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL stall_hold_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_rob_entry !== 4'd7) begin miscompares++; $display("FAIL stall_hold_rob: got %0d want 7", bus.out_rob_entry); end
        rdy = 1'b1;
        step();
        vectors++; if (bus.out_config !== 1'b1) begin miscompares++; $display("FAIL stall_second_cfg: got %0b want 1", bus.out_config); end
        vectors++; if (bus.out_rob_entry !== 4'd8) begin miscompares++; $display("FAIL stall_second_rob: got %0d want 8", bus.out_rob_entry); end
        for (int t = 0; t < 3; t++) begin
            step();
            vectors++; if (bus.out_config !== 1'b0) begin miscompares++; $display("FAIL stall_no_dup: got %0b rob %0d want 0", bus.out_config, bus.out_rob_entry); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_rollback();
        test_rdy_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
